// File: rtl/word_byte_unloader.sv
// ----------------------------------------------------------------------------
// word_byte_unloader
//
// Reader side of the word load register. A parallel word is captured on Load
// and streamed out one byte lane at a time over a valid/ready handshake.
// Byte lanes line up with the register's BYTE_W-bit slices: lane0 is
// D[BYTE_W-1:0], lane NB-1 is D[WORD_W-1:WORD_W-BYTE_W].
//
// Handshake rules (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   On the input side the "valid" is Load and the "ready" is in_ready; on the
//   output side they are out_valid and out_ready. A producer holding valid
//   must keep its data stable until the transfer edge; the unit keeps
//   out_byte/out_last stable while out_valid=1 and out_ready=0. Load while
//   in_ready=0 is simply not a transfer.
//
// Parameters
//   WORD_W     width of the captured word (integer multiple of BYTE_W)
//   BYTE_W     width of each output beat
//   LSB_FIRST  1: lane0 first, 0: highest lane first
//
// Ports
//   clk        in   rising-edge clock
//   clear      in   asynchronous active-high reset; drops any word in flight
//   D          in   word to unload
//   Load       in   capture request, honoured only while in_ready=1
//   in_ready   out  unit can accept a word this cycle (combinational)
//   out_byte   out  current byte lane (0 while idle)
//   out_valid  out  out_byte is valid
//   out_ready  in   consumer accepts out_byte this cycle
//   out_last   out  current beat is the final lane of the word
//   done       out  one-cycle pulse after the final beat is accepted
// ----------------------------------------------------------------------------
module word_byte_unloader #(
    parameter int WORD_W    = 32,
    parameter int BYTE_W    = 8,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [WORD_W-1:0] D,
    input  logic              Load,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done
);

    // Beats per word and the beat counter width (at least one bit so the
    // single-beat configuration still has a legal counter).
    localparam int NB    = WORD_W / BYTE_W;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_done;
    logic              w_done_nxt;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic              w_send;
    logic              w_last;
    logic              w_beat;
    logic              w_in_ready;
    logic              w_accept;
    logic [BYTE_W-1:0] w_lane;
    logic [WORD_W-1:0] w_shifted;

    assign w_send = (r_state == SEND);
    assign w_last = w_send && (r_cnt == LAST_CNT);
    assign w_beat = w_send && out_ready;

    // The unit can take a new word when idle, or in the very cycle its last
    // beat is being accepted; the latter is what lets words run back to back
    // without an idle cycle in between.
    assign w_in_ready = (r_state == IDLE) || (w_last && out_ready);
    assign w_accept   = Load && w_in_ready;

    // The current lane always sits at one end of the shift register, so the
    // output mux is a fixed slice and each accepted beat shifts by one lane.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_lane    = r_shift[BYTE_W-1:0];
            assign w_shifted = r_shift >> BYTE_W;
        end else begin : g_msb_first
            assign w_lane    = r_shift[WORD_W-1 -: BYTE_W];
            assign w_shifted = r_shift << BYTE_W;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = SEND;
                    w_shift_nxt = D;
                    w_cnt_nxt   = '0;
                end
            end

            SEND: begin
                if (w_beat) begin
                    if (w_last) begin
                        // Final lane leaves: done pulses next cycle whether or
                        // not a following word is captured at the same edge.
                        w_done_nxt = 1'b1;
                        if (w_accept) begin
                            w_state_nxt = SEND;
                            w_shift_nxt = D;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_shift_nxt = w_shifted;
                        w_cnt_nxt   = r_cnt + CNT_ONE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // out_byte is forced to zero outside SEND so that an idle or freshly
    // cleared unit never shows a stale lane.
    assign in_ready  = w_in_ready;
    assign out_valid = w_send;
    assign out_byte  = w_send ? w_lane : '0;
    assign out_last  = w_last;
    assign done      = r_done;

endmodule
